// File: rtl/swap_chk_pkg.sv
// Shared types and constants for the swap checker: FSM state encoding,
// the delay-depth bound and the bit layout of the first-mismatch snapshot.
package swap_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int LAT_MAX = 4;
  localparam int FILL_W  = $clog2(LAT_MAX);

  // Layout of first_err_bits: {exp_a, exp_b, a_o, b_o}
  localparam int ERR_BIT_EXP_A = 3;
  localparam int ERR_BIT_EXP_B = 2;
  localparam int ERR_BIT_OBS_A = 1;
  localparam int ERR_BIT_OBS_B = 0;

endpackage

// File: rtl/swap_chk_delay.sv
// LATENCY-deep shift register for the {b_i,a_i} stimulus pair; the tail is
// the expected {a_o,b_o}. Shifts while enabled, flushes to zero otherwise.
module swap_chk_delay
  import swap_chk_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_line [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_line[i] <= '0;
    end else if (!i_en) begin
      for (int i = 0; i < LATENCY; i++) r_line[i] <= '0;
    end else begin
      r_line[0] <= i_d;
      for (int i = 1; i < LATENCY; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign o_q = r_line[LATENCY-1];

endmodule

// File: rtl/swap_checker.sv
// Cycle-accurate checker for the two-bit register-swap block.
// Optional first-mismatch capture is built when SWAP_CHK_CAPTURE_EN is defined.
module swap_checker
  import swap_chk_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int CNT_W      = 8,
  parameter int CHK_W      = 16,
  parameter int MIN_CHECKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             a_o,
  input  logic             b_o,
  output logic [CHK_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             pass,
  output logic             fail,
  output logic [CHK_W-1:0] first_err_idx,
  output logic [3:0]       first_err_bits
);

  state_t              r_state;
  logic [FILL_W-1:0]   r_fill;
  logic [CHK_W-1:0]    r_chk_cnt;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                r_fail;
  logic [1:0]          w_exp;
  logic                w_compare;
  logic                w_mismatch;

  swap_chk_delay #(.LATENCY(LATENCY)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (en),
    .i_d   ({b_i, a_i}),
    .o_q   (w_exp)
  );

  // Case-inequality so an X/Z on the observed outputs counts as a mismatch
  assign w_compare  = (r_state == CHECK) && en;
  assign w_mismatch = w_compare && ({a_o, b_o} !== w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fill  <= '0;
    end else if (!en) begin
      r_state <= IDLE;
      r_fill  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FILL;
          r_fill  <= '0;
        end
        FILL: begin
          if (r_fill == FILL_W'(LATENCY - 1)) r_state <= CHECK;
          r_fill <= r_fill + 1'b1;
        end
        CHECK:   r_state <= CHECK;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_cnt <= '0;
      r_err_cnt <= '0;
      r_fail    <= 1'b0;
    end else if (clr) begin
      r_chk_cnt <= '0;
      r_err_cnt <= '0;
      r_fail    <= 1'b0;
    end else if (w_compare) begin
      if (!(&r_chk_cnt)) r_chk_cnt <= r_chk_cnt + 1'b1;
      if (w_mismatch) begin
        if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
        r_fail <= 1'b1;
      end
    end
  end

`ifdef SWAP_CHK_CAPTURE_EN
  logic [CHK_W-1:0] r_first_idx;
  logic [3:0]       r_first_bits;

  // r_fail low means no mismatch has been latched since reset/clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_idx  <= '0;
      r_first_bits <= '0;
    end else if (clr) begin
      r_first_idx  <= '0;
      r_first_bits <= '0;
    end else if (w_mismatch && !r_fail) begin
      r_first_idx                 <= r_chk_cnt;
      r_first_bits[ERR_BIT_EXP_A] <= w_exp[1];
      r_first_bits[ERR_BIT_EXP_B] <= w_exp[0];
      r_first_bits[ERR_BIT_OBS_A] <= a_o;
      r_first_bits[ERR_BIT_OBS_B] <= b_o;
    end
  end

  assign first_err_idx  = r_first_idx;
  assign first_err_bits = r_first_bits;
`else
  assign first_err_idx  = '0;
  assign first_err_bits = '0;
`endif

  assign chk_cnt = r_chk_cnt;
  assign err_cnt = r_err_cnt;
  assign fail    = r_fail;
  assign pass    = (r_state == CHECK) && (r_err_cnt == '0) && !r_fail &&
                   (r_chk_cnt >= CHK_W'(MIN_CHECKS));

endmodule
